// File: rtl/gemm_stream_sequencer.sv
// Stream sequencer for the fixed-weights GEMM array: feeds rows, tracks
// real-row tags through the skew pipeline and presents results in order.
module gemm_stream_sequencer #(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int ROW_CNT_W              = 16,
  parameter int LATENCY                = 2 * SA_SIZE
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [ROW_CNT_W-1:0]                          num_rows,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] in_data,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_act_in,
  output logic                                          sa_advance,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] sa_act_out,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] out_data,
  output logic                                          busy,
  output logic                                          done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ROW_CNT_W-1:0] ONE = ROW_CNT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [ROW_CNT_W-1:0] m_q, m_d;
  logic [ROW_CNT_W-1:0] rows_in_q, rows_in_d;
  logic [ROW_CNT_W-1:0] rows_out_q, rows_out_d;
  logic [LATENCY-1:0]   tags_q, tags_d;
  logic                 taken_q, taken_d;

  logic                 tail;
  logic                 stall;
  logic                 accept;
  logic                 handoff;
  logic [ROW_CNT_W-1:0] out_cnt;

  assign tail      = tags_q[LATENCY-1];
  assign out_valid = tail && !taken_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = (state_q == S_STREAM) && (rows_in_q < m_q) && !stall;
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign out_cnt   = handoff ? rows_out_q + ONE : rows_out_q;
  assign sa_act_in = accept ? in_data : '0;
  assign out_data  = sa_act_out;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Drain stops on the cycle the last result is taken, so no extra shift.
  always_comb begin
    sa_advance = 1'b0;
    case (state_q)
      S_STREAM: sa_advance = accept;
      S_DRAIN:  sa_advance = !stall && (out_cnt != m_q);
      default:  sa_advance = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    rows_in_d  = accept ? rows_in_q + ONE : rows_in_q;
    rows_out_d = out_cnt;
    tags_d     = tags_q;
    taken_d    = taken_q;
    if (sa_advance) begin
      tags_d  = {tags_q[LATENCY-2:0], accept};
      taken_d = 1'b0;
    end else if (handoff) begin
      taken_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d        = num_rows;
          rows_in_d  = '0;
          rows_out_d = '0;
          tags_d     = '0;
          taken_d    = 1'b0;
          state_d    = (num_rows == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && (rows_in_d == m_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (handoff && (out_cnt == m_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      tags_q     <= '0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      tags_q     <= tags_d;
      taken_q    <= taken_d;
    end
  end

endmodule

// File: tb/tb_gemm_stream_sequencer.sv
// Directed bench for gemm_stream_sequencer with a behavioural
// fixed-weights array model in the loop.
module tb_gemm_stream_sequencer;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int LAT = 2 * N;

  typedef logic [N-1:0][W-1:0] row_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_rows;
  logic          in_valid;
  logic          in_ready;
  row_t          in_data;
  row_t          sa_act_in;
  logic          sa_advance;
  row_t          sa_act_out;
  logic          out_valid;
  logic          out_ready;
  row_t          out_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  gemm_stream_sequencer #(
    .SA_SIZE(N), .WEIGHT_ACTIVATION_SIZE(W),
    .ROW_CNT_W(CW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sa_act_in(sa_act_in), .sa_advance(sa_advance),
    .sa_act_out(sa_act_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // weights w[i][j] = i+j+1
  function automatic row_t gemm(input row_t a);
    row_t r;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(a[i]) * (i + j + 1);
      r[j] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic row_t mkrow(input int k);
    row_t r;
    for (int i = 0; i < N; i++) r[i] = W'(k * 4 + i + 1);
    return r;
  endfunction

  row_t pipe [LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (sa_advance) begin
      pipe[0] <= gemm(sa_act_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sa_act_out = pipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc_n, acc_n, hs_n, adv_n, done_n;
  int first_acc, first_val, last_hs, done_cyc;
  row_t got[$];
  row_t exp_q[$];

  task automatic clear_stats();
    cyc_n = 0; acc_n = 0; hs_n = 0; adv_n = 0; done_n = 0;
    first_acc = -1; first_val = -1; last_hs = -1; done_cyc = -1;
    got.delete(); exp_q.delete();
  endtask

  task automatic step();
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(gemm(in_data));
      if (first_acc < 0) first_acc = cyc_n;
      acc_n++;
    end
    if (out_valid && first_val < 0) first_val = cyc_n;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      last_hs = cyc_n;
      hs_n++;
    end
    if (sa_advance) adv_n++;
    if (done) begin
      done_cyc = cyc_n;
      done_n++;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; num_rows = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_job(input int m);
    num_rows = CW'(m);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({in_ready, sa_advance, out_valid, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {in_ready, sa_advance, out_valid, busy, done});
    end
    checks++;
    if (sa_act_in !== '0) begin
      failures++;
      $display("FAIL reset_act_in got=%h exp=0", sa_act_in);
    end
  endtask

  task automatic test_back_to_back();
    row_t gold;
    gold = {8'd22, 8'd18, 8'd14, 8'd10};
    clear_stats();
    start_job(3);
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_start got=%b%b exp=11", busy, in_ready);
    end
    in_valid = 1'b1; out_ready = 1'b1; in_data = {4{8'd1}};
    for (int i = 0; i < 40 && done_n == 0; i++) step();
    in_valid = 1'b0;
    checks++;
    if (done_n != 1) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d exp=1", done_n);
    end
    checks++;
    if (first_val - first_acc != LAT) begin
      failures++;
      $display("FAIL b2b_latency got=%0d exp=%0d", first_val - first_acc, LAT);
    end
    checks++;
    if (hs_n != 3) begin
      failures++;
      $display("FAIL b2b_handshakes got=%0d exp=3", hs_n);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== gold) begin
        failures++;
        $display("FAIL b2b_data%0d got=%h exp=%h", k, got[k], gold);
      end
    end
    checks++;
    if (done_cyc != last_hs + 1) begin
      failures++;
      $display("FAIL b2b_done_cycle got=%0d exp=%0d", done_cyc, last_hs + 1);
    end
    checks++;
    if (adv_n != 10) begin
      failures++;
      $display("FAIL b2b_advances got=%0d exp=10", adv_n);
    end
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b%b exp=00", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int   left;
    row_t held;
    left = 5;
    held = '0;
    clear_stats();
    start_job(10);
    out_ready = 1'b1;
    for (int i = 0; i < 80 && done_n == 0; i++) begin
      in_data  = mkrow(acc_n);
      in_valid = (acc_n < 10);
      if (out_valid && left > 0) begin
        out_ready = 1'b0;
        if (left == 5) held = out_data;
        #1;
        checks++;
        if (sa_advance !== 1'b0 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_stall got=%b%b exp=00", sa_advance, in_ready);
        end
        checks++;
        if (out_data !== held) begin
          failures++;
          $display("FAIL bp_hold got=%h exp=%h", out_data, held);
        end
        left--;
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (done_n != 1 || hs_n != 10 || got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d/%0d/%0d exp=1/10/%0d",
               done_n, hs_n, got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== gemm(mkrow(k))) begin
        failures++;
        $display("FAIL bp_data%0d got=%h exp=%h", k, got[k], gemm(mkrow(k)));
      end
    end
  endtask

  task automatic test_gaps();
    clear_stats();
    start_job(4);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && done_n == 0; i++) begin
      in_data  = mkrow(acc_n + 20);
      in_valid = (i % 2 == 0) && (acc_n < 4);
      if (!in_valid && acc_n < 4) begin
        #1;
        checks++;
        if (sa_advance !== 1'b0) begin
          failures++;
          $display("FAIL gap_advance got=%b exp=0", sa_advance);
        end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (done_n != 1 || hs_n != 4) begin
      failures++;
      $display("FAIL gap_count got=%0d/%0d exp=1/4", done_n, hs_n);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== gemm(mkrow(k + 20))) begin
        failures++;
        $display("FAIL gap_data%0d got=%h exp=%h", k, got[k],
                 gemm(mkrow(k + 20)));
      end
    end
  endtask

  task automatic test_handoff();
    int ph;
    int gap;
    ph = 0;
    gap = 0;
    clear_stats();
    start_job(10);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && done_n == 0; i++) begin
      in_data = mkrow(acc_n + 40);
      if (ph == 0 && out_valid) begin
        in_valid = 1'b0;
        #1;
        checks++;
        if (sa_advance !== 1'b0) begin
          failures++;
          $display("FAIL ho_advance got=%b exp=0", sa_advance);
        end
        ph = 1;
        gap = 3;
      end else if (ph == 1) begin
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL ho_repeat got=%b exp=0", out_valid);
        end
        gap--;
        if (gap == 0) ph = 2;
      end else begin
        in_valid = (acc_n < 10);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (done_n != 1 || hs_n != 10) begin
      failures++;
      $display("FAIL ho_count got=%0d/%0d exp=1/10", done_n, hs_n);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== gemm(mkrow(k + 40))) begin
        failures++;
        $display("FAIL ho_data%0d got=%h exp=%h", k, got[k],
                 gemm(mkrow(k + 40)));
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    clear_stats();
    start_job(0);
    #1;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got=%b%b exp=10", done, in_ready);
    end
    step();
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || adv_n != 0) begin
      failures++;
      $display("FAIL zero_end got=%b%b/%0d exp=00/0", done, busy, adv_n);
    end
    clear_stats();
    start_job(2);
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = mkrow(60);
    step();
    in_data = mkrow(61);
    num_rows = CW'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      in_data = mkrow(60 + acc_n);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (acc_n != 2 || hs_n != 2 || done_n != 1) begin
      failures++;
      $display("FAIL ign_count got=%0d/%0d/%0d exp=2/2/1",
               acc_n, hs_n, done_n);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== gemm(mkrow(60 + k))) begin
        failures++;
        $display("FAIL ign_data%0d got=%h exp=%h", k, got[k],
                 gemm(mkrow(60 + k)));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int extra;
    extra = 0;
    clear_stats();
    start_job(3);
    in_valid = 1'b1; out_ready = 1'b1; in_data = mkrow(80);
    for (int i = 0; i < 20 && extra < 3; i++) begin
      if (acc_n >= 3) extra++;
      step();
    end
    in_valid = 1'b0;
    clear_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, sa_advance, out_valid, busy, done} !== 5'b0 ||
        sa_act_in !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=00000",
               {in_ready, sa_advance, out_valid, busy, done});
    end
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (done_n != 0 || hs_n != 0) begin
      failures++;
      $display("FAIL mid_quiet got=%0d/%0d exp=0/0", done_n, hs_n);
    end
    clear_stats();
    start_job(2);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      in_data = mkrow(90 + acc_n);
      in_valid = (acc_n < 2);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (done_n != 1 || hs_n != 2 || first_val - first_acc != LAT) begin
      failures++;
      $display("FAIL post_count got=%0d/%0d/%0d exp=1/2/%0d",
               done_n, hs_n, first_val - first_acc, LAT);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== gemm(mkrow(90 + k))) begin
        failures++;
        $display("FAIL post_data%0d got=%h exp=%h", k, got[k],
                 gemm(mkrow(90 + k)));
      end
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_handoff();
    test_zero_and_ignored_start();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
